signed_restoring_divider: RTL and testbench

- Multi-cycle signed integer divider. It is the inverse operation of the team's combinational signed Wallace multiplier and sits beside it in the multdiv unit.
- Takes two's-complement dividend and divisor, converts both to magnitudes, runs one restoring-division step per clock, then sign-corrects the results.
- Uses a start/done handshake so the multdiv controller can stall while a divide is in progress.

---
 rtl/signed_restoring_divider.sv | 158 +++++++++++++++
 tb/tb_signed_restoring_divider.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/signed_restoring_divider.sv
// ---------------------------------------------------------------------------
// signed_restoring_divider
//   Multi-cycle two's-complement divider for the multdiv unit. Operands are
//   reduced to magnitudes on start, one restoring-division step runs per
//   clock, and the results are sign-corrected in a final FIXUP cycle.
//   Latency from the accepting edge: WIDTH+1 edges, or 1 edge for divide
//   by zero.
//
// Ports
//   clock, reset     rising-edge clock, synchronous active-high reset
//   start            request, sampled only while busy=0
//   dividend/divisor signed operands, captured on the accepting edge
//   quotient         signed quotient, truncated toward zero
//   remainder        signed remainder, sign follows dividend
//   busy             operation in flight
//   done             one-cycle completion pulse
//   ovf              MIN / -1 overflow, valid with done
//   div_by_zero      divisor was zero, valid with done
// ---------------------------------------------------------------------------
module signed_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, ZERO} state_t;

    state_t           state, state_next;
    logic             accept;
    logic             sign_q, sign_r, ovf_pend;
    // dvd_mag starts as |dividend|; quotient bits shift in from the right as
    // dividend bits shift out the top, so after WIDTH steps it holds |q|.
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    // Partial remainder is always < |divisor| <= 2^(WIDTH-1), so WIDTH bits
    // suffice between steps; the shift below supplies the extra top bit.
    logic [WIDTH-1:0] prem;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] dividend_abs, divisor_abs;
    logic [WIDTH-1:0] q_fix, r_fix, dvd_signed;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (divisor == '0) ? ZERO : RUN;
                end
            end
            RUN:     if (cnt == CNT_W'(1)) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            ZERO:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- datapath helpers ----------------
    always_comb begin
        // |MIN| wraps to MIN, which read unsigned is exactly 2^(WIDTH-1).
        dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
        divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;
        shifted      = {prem, dvd_mag[WIDTH-1]};
        trial        = shifted - {1'b0, dvs_mag};
        q_fix        = sign_q ? -dvd_mag : dvd_mag;
        r_fix        = sign_r ? -prem    : prem;
        // In ZERO the magnitude register is untouched, so this rebuilds the
        // captured dividend without storing it separately.
        dvd_signed   = sign_r ? -dvd_mag : dvd_mag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            ovf_pend    <= 1'b0;
            dvd_mag     <= '0;
            dvs_mag     <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r      <= dividend[WIDTH-1];
                        ovf_pend    <= (dividend == MIN_VAL) && (divisor == '1);
                        dvd_mag     <= dividend_abs;
                        dvs_mag     <= divisor_abs;
                        prem        <= '0;
                        cnt         <= CNT_W'(WIDTH);
                        busy        <= 1'b1;
                        ovf         <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    // trial[WIDTH] is the borrow: set means restore.
                    if (!trial[WIDTH]) begin
                        prem    <= trial[WIDTH-1:0];
                        dvd_mag <= {dvd_mag[WIDTH-2:0], 1'b1};
                    end else begin
                        prem    <= shifted[WIDTH-1:0];
                        dvd_mag <= {dvd_mag[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                end
                FIXUP: begin
                    // MIN / -1 needs no special path: |q| = 2^(WIDTH-1) with
                    // sign_q=0 already reads as MIN, and the remainder is 0.
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    ovf       <= ovf_pend;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                ZERO: begin
                    quotient    <= '0;
                    remainder   <= dvd_signed;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_signed_restoring_divider
//   Directed vectors plus a full WIDTH=4 sweep. The driver pushes the
//   expected response (and the cycle it should appear in) for every start
//   the DUT accepts; a monitor pops and compares on each done pulse.
// ---------------------------------------------------------------------------
module tb_signed_restoring_divider;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset, start;
    logic [W-1:0] dividend, divisor;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, ovf, div_by_zero;

    signed_restoring_divider #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .busy(busy), .done(done), .ovf(ovf), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         o, z;
        bit           ident;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   prev_done = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Sweep entries are judged by the division identity and flag rules.
    task automatic ident_check(input exp_t e);
        int ai, bi, qi, ri;
        ai = $signed(e.a);
        bi = $signed(e.b);
        qi = $signed(quotient);
        ri = $signed(remainder);
        if (bi == 0) begin
            chk($sformatf("sweep_dbz a=%0d", ai), 32'(div_by_zero), 32'd1);
            chk($sformatf("sweep_dbz_ovf a=%0d", ai), 32'(ovf), 32'd0);
            chk($sformatf("sweep_dbz_q a=%0d", ai), 32'(quotient), 32'd0);
            chk($sformatf("sweep_dbz_r a=%0d", ai), 32'(remainder), 32'(e.a));
        end else begin
            chk($sformatf("sweep_nodbz a=%0d b=%0d", ai, bi), 32'(div_by_zero), 32'd0);
            chk($sformatf("sweep_ovf a=%0d b=%0d", ai, bi), 32'(ovf),
                32'(ai == -8 && bi == -1));
            chk($sformatf("sweep_identity a=%0d b=%0d", ai, bi),
                32'((qi * bi + ri - ai) & 15), 32'd0);
            if (ai == -8 && bi == -1) begin
                chk("sweep_ovf_q", 32'(quotient), 32'h8);
                chk("sweep_ovf_r", 32'(remainder), 32'h0);
            end else begin
                chk($sformatf("sweep_rem_mag a=%0d b=%0d", ai, bi),
                    32'(((ri < 0) ? -ri : ri) < ((bi < 0) ? -bi : bi)), 32'd1);
                chk($sformatf("sweep_rem_sign a=%0d b=%0d", ai, bi),
                    32'(ri == 0 || ((ri < 0) == (ai < 0))), 32'd1);
            end
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clock) begin
        if (!reset && done) begin
            chk("done_single_cycle", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required no pending operation");
            end else begin
                mon_e = sb.pop_front();
                chk("latency", 32'(cyc), 32'(mon_e.cyc));
                chk("busy_at_done", 32'(busy), 32'd0);
                if (mon_e.ident) ident_check(mon_e);
                else begin
                    chk("quotient", 32'(quotient), 32'(mon_e.q));
                    chk("remainder", 32'(remainder), 32'(mon_e.r));
                    chk("ovf", 32'(ovf), 32'(mon_e.o));
                    chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.z));
                end
            end
        end
        prev_done = done;
    end

    // Called at a negedge; returns one negedge later with start dropped.
    task automatic issue(input logic [W-1:0] a, b, q, r, input logic o, z, input bit ident);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (!busy) begin
            e.a = a; e.b = b; e.q = q; e.r = r; e.o = o; e.z = z;
            e.ident = ident;
            e.cyc   = cyc + 1 + ((b == '0) ? 1 : W + 1);
            sb.push_back(e);
        end
        @(negedge clock);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !done; i++) @(negedge clock);
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_done: got no done within 20 cycles required done");
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_q"},    32'(quotient), 32'd0);
        chk({tag, "_r"},    32'(remainder), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ovf"},  32'(ovf), 32'd0);
        chk({tag, "_dbz"},  32'(div_by_zero), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clock);
        chk_zero_outputs("reset_state");
        reset = 1'b0;
        @(negedge clock);

        // 7/2 with busy profile
        issue(4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("busy_running", 32'(busy), 32'd1);
            if (i < 3) @(negedge clock);
        end
        wait_done();
        // signs, overflow, MIN/1, back-to-back each time
        issue(4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0, 1'b0); wait_done();
        issue(4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0, 1'b0); wait_done();
        issue(4'h8, 4'hF, 4'h8, 4'h0, 1'b1, 1'b0, 1'b0); wait_done();
        issue(4'h8, 4'h1, 4'h8, 4'h0, 1'b0, 1'b0, 1'b0); wait_done();
        issue(4'h5, 4'h0, 4'h0, 4'h5, 1'b0, 1'b1, 1'b0); wait_done();

        // flags and results hold, then clear on the next accepted start
        repeat (2) @(negedge clock);
        chk("dbz_hold", 32'(div_by_zero), 32'd1);
        chk("rem_hold", 32'(remainder), 32'd5);
        issue(4'h6, 4'h3, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("dbz_cleared", 32'(div_by_zero), 32'd0);
        chk("rem_kept_until_write", 32'(remainder), 32'd5);
        @(negedge clock);
        chk("busy_when_ignored", 32'(busy), 32'd1);
        issue(4'h1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);   // ignored: busy
        wait_done();
        issue(4'h1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);   // accepted in done cycle
        wait_done();
        @(negedge clock);

        // reset mid-operation aborts without a done pulse
        issue(4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        chk_zero_outputs("abort_a");
        @(negedge clock);
        chk_zero_outputs("abort_b");
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        issue(4'h6, 4'hD, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0); wait_done();

        // full sweep, back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(W'(a), W'(b), 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
                wait_done();
            end
        end
        @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
